// File: rtl/ram128_arb_pkg.sv
// Shared types and constants for the RAM128 two-requester arbiter.
package ram128_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned ARB_ADDR_W = 7;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_BE_W   = ARB_DATA_W / 8;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/ram128_arbiter_rr_arb2.sv
// Two-way round-robin picker; the priority register lives in the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // A lone request always wins; a tie goes to the requester named by prio.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !prio)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
    gnt_id = gnt[1];
  end

endmodule

// File: rtl/ram128_arbiter.sv
// Round-robin arbiter and access sequencer in front of the RAM128 macro.
module ram128_arbiter
  import ram128_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W = ARB_ADDR_W,
  parameter  int unsigned DATA_W = ARB_DATA_W,
  parameter  int unsigned RD_LAT = 1,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_valid,
  input  logic [BE_W-1:0]   m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_resp_valid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [BE_W-1:0]   m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_resp_valid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_EN0,
  output logic [BE_W-1:0]   ram_WE0,
  output logic [ADDR_W-1:0] ram_A0,
  output logic [DATA_W-1:0] ram_Di0,
  input  logic [DATA_W-1:0] ram_Do0,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  state_e            state;
  logic              prio;
  logic              owner;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]        gnt_c;
  logic              gnt_id_c;
  logic              grant_ok_c;
  logic [BE_W-1:0]   sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  rr_arb2 u_pick (
    .req    ({m1_valid, m0_valid}),
    .prio   (prio),
    .gnt    (gnt_c),
    .gnt_id (gnt_id_c)
  );

  // Grants are only visible while idle and out of reset.
  assign grant_ok_c = (state == IDLE) && !RST;
  assign m0_ready   = grant_ok_c && gnt_c[0];
  assign m1_ready   = grant_ok_c && gnt_c[1];

  // Route the winning requester's payload toward the RAM registers.
  always_comb begin
    sel_we_c    = m0_we;
    sel_addr_c  = m0_addr;
    sel_wdata_c = m0_wdata;
    if (gnt_id_c) begin
      sel_we_c    = m1_we;
      sel_addr_c  = m1_addr;
      sel_wdata_c = m1_wdata;
    end
  end

  // Sequencer: accept, drive the RAM for one cycle, wait out read latency, respond.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      prio          <= 1'b0;
      owner         <= 1'b0;
      cnt           <= '0;
      busy          <= 1'b0;
      ram_EN0       <= 1'b0;
      ram_WE0       <= '0;
      ram_A0        <= '0;
      ram_Di0       <= '0;
      m0_resp_valid <= 1'b0;
      m1_resp_valid <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt_c) begin
            state   <= ACCESS;
            busy    <= 1'b1;
            owner   <= gnt_id_c;
            prio    <= !gnt_id_c;
            ram_EN0 <= 1'b1;
            ram_WE0 <= sel_we_c;
            ram_A0  <= sel_addr_c;
            ram_Di0 <= sel_wdata_c;
          end
        end
        ACCESS: begin
          ram_EN0 <= 1'b0;
          ram_WE0 <= '0;
          ram_A0  <= '0;
          ram_Di0 <= '0;
          if (ram_WE0 == '0) begin
            state <= WAIT;
            cnt   <= '0;
          end else begin
            state <= DONE;
            if (owner) begin
              m1_resp_valid <= 1'b1;
              m1_rdata      <= '0;
            end else begin
              m0_resp_valid <= 1'b1;
              m0_rdata      <= '0;
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state <= DONE;
            cnt   <= '0;
            if (owner) begin
              m1_resp_valid <= 1'b1;
              m1_rdata      <= ram_Do0;
            end else begin
              m0_resp_valid <= 1'b1;
              m0_rdata      <= ram_Do0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state         <= IDLE;
          busy          <= 1'b0;
          m0_resp_valid <= 1'b0;
          m1_resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram128_arbiter.sv
// Bench for ram128_arbiter: transaction-level reference model plus RAM128 behavioural model.
module tb_ram128_arbiter;
  import ram128_arb_pkg::*;

  localparam int unsigned AW    = ARB_ADDR_W;
  localparam int unsigned DW    = ARB_DATA_W;
  localparam int unsigned BW    = ARB_BE_W;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;

  logic CLK = 1'b0;
  logic RST;
  logic ram_init;
  always #5 CLK = ~CLK;

  // Instance A (RD_LAT=1) signals
  logic          m_valid [2];
  logic [BW-1:0] m_we    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic          m0_ready, m1_ready, m0_resp, m1_resp, busy_a;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en_a;
  logic [BW-1:0] ram_we_a;
  logic [AW-1:0] ram_a_a;
  logic [DW-1:0] ram_di_a, ram_do_a;

  // Instance B (RD_LAT=3) signals
  logic          b_m0_valid, b_m1_valid;
  logic [BW-1:0] b_m0_we, b_m1_we;
  logic [AW-1:0] b_m0_addr, b_m1_addr;
  logic [DW-1:0] b_m0_wdata, b_m1_wdata;
  logic          b_m0_ready, b_m1_ready, b_m0_resp, b_m1_resp, busy_b;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata;
  logic          ram_en_b;
  logic [BW-1:0] ram_we_b;
  logic [AW-1:0] ram_a_b;
  logic [DW-1:0] ram_di_b, ram_do_b;

  ram128_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_A)) u_dut (
    .CLK(CLK), .RST(RST),
    .m0_valid(m_valid[0]), .m0_we(m_we[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]),
    .m0_ready(m0_ready), .m0_resp_valid(m0_resp), .m0_rdata(m0_rdata),
    .m1_valid(m_valid[1]), .m1_we(m_we[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]),
    .m1_ready(m1_ready), .m1_resp_valid(m1_resp), .m1_rdata(m1_rdata),
    .ram_EN0(ram_en_a), .ram_WE0(ram_we_a), .ram_A0(ram_a_a), .ram_Di0(ram_di_a),
    .ram_Do0(ram_do_a), .busy(busy_a)
  );

  ram128_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B)) u_dut_lat3 (
    .CLK(CLK), .RST(RST),
    .m0_valid(b_m0_valid), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_ready(b_m0_ready), .m0_resp_valid(b_m0_resp), .m0_rdata(b_m0_rdata),
    .m1_valid(b_m1_valid), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ready(b_m1_ready), .m1_resp_valid(b_m1_resp), .m1_rdata(b_m1_rdata),
    .ram_EN0(ram_en_b), .ram_WE0(ram_we_b), .ram_A0(ram_a_b), .ram_Di0(ram_di_b),
    .ram_Do0(ram_do_b), .busy(busy_b)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return (32'h9E3779B9 * 32'(i)) ^ 32'h5A5A0F0F;
  endfunction

  // RAM128 behavioural models: byte writes, read data after the configured latency, noise otherwise.
  logic [DW-1:0] mem_a [128];
  logic [DW-1:0] mem_b [128];
  logic [DW-1:0] pipe_a [LAT_A];
  logic [DW-1:0] pipe_b [LAT_B];

  always @(posedge CLK) begin
    if (ram_init) begin
      for (int i = 0; i < 128; i++) mem_a[i] <= init_val(i);
    end else begin
      for (int b = 0; b < int'(BW); b++)
        if (ram_en_a && ram_we_a[b]) mem_a[ram_a_a][b*8 +: 8] <= ram_di_a[b*8 +: 8];
    end
    pipe_a[0] <= (ram_en_a && ram_we_a == '0) ? mem_a[ram_a_a] : DW'($urandom);
    for (int i = 1; i < int'(LAT_A); i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign ram_do_a = pipe_a[LAT_A-1];

  always @(posedge CLK) begin
    if (ram_init) begin
      for (int i = 0; i < 128; i++) mem_b[i] <= init_val(i);
    end else begin
      for (int b = 0; b < int'(BW); b++)
        if (ram_en_b && ram_we_b[b]) mem_b[ram_a_b][b*8 +: 8] <= ram_di_b[b*8 +: 8];
    end
    pipe_b[0] <= (ram_en_b && ram_we_b == '0) ? mem_b[ram_a_b] : DW'($urandom);
    for (int i = 1; i < int'(LAT_B); i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign ram_do_b = pipe_b[LAT_B-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: transaction timing derived from the accept cycle plus a memory image.
  int            cyc = 0;
  int            free_at = 0;
  int            acc_at = -1;
  int            resp_at = -1;
  int            last_win;
  bit            mprio = 1'b0;
  bit            mowner = 1'b0;
  logic [BW-1:0] e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_resp_data;
  logic [DW-1:0] model_rdata [2];
  logic [DW-1:0] model_mem [128];

  bit            pend [2];
  logic [BW-1:0] p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];

  task automatic new_req(input int k);
    pend[k]    = 1'b1;
    p_we[k]    = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom_range(1, 15));
    p_addr[k]  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    p_wdata[k] = DW'($urandom);
  endtask

  // One cycle on instance A: check registered outputs, drive, check ready, record accept.
  task automatic step(input bit rnd);
    int w;
    bit idle;
    @(negedge CLK);
    cyc++;
    if (cyc == resp_at) model_rdata[mowner] = e_resp_data;
    chk("ram_EN0", 32'(ram_en_a), 32'(cyc == acc_at));
    chk("ram_WE0", 32'(ram_we_a), (cyc == acc_at) ? 32'(e_we) : 32'h0);
    chk("ram_A0",  32'(ram_a_a),  (cyc == acc_at) ? 32'(e_addr) : 32'h0);
    chk("ram_Di0", ram_di_a,      (cyc == acc_at) ? e_wdata : 32'h0);
    chk("m0_resp_valid", 32'(m0_resp), 32'(cyc == resp_at && !mowner));
    chk("m1_resp_valid", 32'(m1_resp), 32'(cyc == resp_at && mowner));
    chk("m0_rdata", m0_rdata, model_rdata[0]);
    chk("m1_rdata", m1_rdata, model_rdata[1]);
    chk("busy", 32'(busy_a), 32'(cyc < free_at));
    for (int k = 0; k < 2; k++) begin
      if (rnd) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) new_req(k);
        else if (pend[k] && $urandom_range(0, 15) == 0) pend[k] = 1'b0;
      end
      m_valid[k] = pend[k];
      m_we[k]    = pend[k] ? p_we[k]    : BW'($urandom);
      m_addr[k]  = pend[k] ? p_addr[k]  : AW'($urandom);
      m_wdata[k] = pend[k] ? p_wdata[k] : DW'($urandom);
    end
    #1;
    idle = (cyc >= free_at);
    w = -1;
    if (idle) begin
      if (pend[0] && pend[1]) w = int'(mprio);
      else if (pend[0])       w = 0;
      else if (pend[1])       w = 1;
    end
    chk("m0_ready", 32'(m0_ready), 32'(w == 0));
    chk("m1_ready", 32'(m1_ready), 32'(w == 1));
    chk("one_ready", 32'(m0_ready & m1_ready), 32'h0);
    last_win = w;
    if (w >= 0) begin
      mowner  = (w == 1);
      mprio   = (w == 0);
      acc_at  = cyc + 1;
      e_we    = p_we[w];
      e_addr  = p_addr[w];
      e_wdata = p_wdata[w];
      if (e_we != '0) begin
        for (int b = 0; b < int'(BW); b++)
          if (e_we[b]) model_mem[e_addr][b*8 +: 8] = e_wdata[b*8 +: 8];
        e_resp_data = '0;
        resp_at     = cyc + 2;
        free_at     = cyc + 3;
      end else begin
        e_resp_data = model_mem[e_addr];
        resp_at     = cyc + 2 + int'(LAT_A);
        free_at     = cyc + 3 + int'(LAT_A);
      end
      pend[w] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && cyc < free_at; n++) step(1'b0);
  endtask

  task automatic issue(input int k, input logic [BW-1:0] we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    pend[k] = 1'b1; p_we[k] = we; p_addr[k] = addr; p_wdata[k] = wd;
    for (int n = 0; n < 40 && pend[k]; n++) step(1'b0);
    if (pend[k]) begin
      chk("accept_timeout", 32'h0, 32'h1);
      pend[k] = 1'b0;
    end
    drain();
  endtask

  // Directed transaction on the RD_LAT=3 instance; response expected resp_off cycles after accept.
  task automatic b_txn(input string tag, input logic [BW-1:0] we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input int resp_off, input logic [DW-1:0] exp_data);
    @(negedge CLK);
    b_m0_valid = 1'b1; b_m0_we = we; b_m0_addr = addr; b_m0_wdata = wd;
    #1;
    chk({tag, "_ready"}, 32'(b_m0_ready), 32'h1);
    @(negedge CLK);
    b_m0_valid = 1'b0;
    chk({tag, "_en_T1"}, 32'(ram_en_b), 32'h1);
    chk({tag, "_a_T1"},  32'(ram_a_b), 32'(addr));
    chk({tag, "_we_T1"}, 32'(ram_we_b), 32'(we));
    for (int t = 2; t <= resp_off; t++) begin
      @(negedge CLK);
      chk({tag, "_resp"}, 32'(b_m0_resp), 32'(t == resp_off));
      chk({tag, "_en_off"}, 32'(ram_en_b), 32'h0);
      chk({tag, "_m1_resp"}, 32'(b_m1_resp), 32'h0);
      #1;
      chk({tag, "_no_ready"}, 32'(b_m0_ready), 32'h0);
    end
    chk({tag, "_rdata"}, b_m0_rdata, exp_data);
    @(negedge CLK);
    chk({tag, "_resp_end"}, 32'(b_m0_resp), 32'h0);
    chk({tag, "_busy_end"}, 32'(busy_b), 32'h0);
  endtask

  initial begin
    int wins [$];
    logic [DW-1:0] exp7f;

    RST = 1'b1;
    ram_init = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; m_valid[k] = 1'b0; m_we[k] = '0; m_addr[k] = '0; m_wdata[k] = '0;
      model_rdata[k] = '0;
    end
    b_m0_valid = 1'b0; b_m0_we = '0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_valid = 1'b0; b_m1_we = '0; b_m1_addr = '0; b_m1_wdata = '0;
    for (int i = 0; i < 128; i++) model_mem[i] = init_val(i);

    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_en", 32'(ram_en_a), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_resp", 32'(m1_resp), 32'h0);
    chk("rst_b_busy", 32'(busy_b), 32'h0);
    RST = 1'b0;
    ram_init = 1'b0;

    // Contention from reset: both requesters keep asking, winners must alternate from m0.
    new_req(0);
    new_req(1);
    for (int n = 0; n < 100 && wins.size() < 4; n++) begin
      step(1'b0);
      if (last_win >= 0) begin
        chk("contention_order", 32'(last_win), 32'(wins.size() % 2));
        wins.push_back(last_win);
        new_req(last_win);
      end
    end
    chk("contention_count", 32'(wins.size()), 32'd4);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drain();

    // Write then read back a full word on m0.
    issue(0, 4'hF, 7'h05, 32'hDEADBEEF);
    issue(0, 4'h0, 7'h05, 32'h0);
    chk("read_05", m0_rdata, 32'hDEADBEEF);

    // Byte-masked write on m1 to the top address, then read back.
    issue(1, 4'b0101, 7'h7F, 32'h11223344);
    chk("bytewr_rdata", m1_rdata, 32'h0);
    issue(1, 4'h0, 7'h7F, 32'h0);
    exp7f = (init_val(7'h7F) & 32'hFF00FF00) | 32'h00220044;
    chk("bytewr_readback", m1_rdata, exp7f);
    chk("m0_rdata_held", m0_rdata, 32'hDEADBEEF);

    // m1 raises a request for one cycle while busy, then withdraws it.
    pend[0] = 1'b1; p_we[0] = 4'hF; p_addr[0] = 7'h20; p_wdata[0] = 32'h0BADF00D;
    for (int n = 0; n < 10 && pend[0]; n++) step(1'b0);
    pend[1] = 1'b1; p_we[1] = 4'h0; p_addr[1] = 7'h21; p_wdata[1] = 32'h0;
    step(1'b0);
    pend[1] = 1'b0;
    drain();
    repeat (3) step(1'b0);

    // Randomised traffic with contention and withdrawals.
    for (int n = 0; n < 1500; n++) step(1'b1);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drain();

    // Reset during a read's WAIT cycle.
    pend[0] = 1'b1; p_we[0] = 4'h0; p_addr[0] = 7'h05; p_wdata[0] = 32'h0;
    for (int n = 0; n < 10 && pend[0]; n++) step(1'b0);
    step(1'b0);
    step(1'b0);
    m_valid[1] = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_en", 32'(ram_en_a), 32'h0);
    chk("midrst_a", 32'(ram_a_a), 32'h0);
    chk("midrst_busy", 32'(busy_a), 32'h0);
    chk("midrst_m0_resp", 32'(m0_resp), 32'h0);
    chk("midrst_m0_rdata", m0_rdata, 32'h0);
    chk("midrst_m1_rdata", m1_rdata, 32'h0);
    chk("midrst_m1_ready", 32'(m1_ready), 32'h0);
    mprio = 1'b0; free_at = 0; acc_at = -1; resp_at = -1;
    model_rdata[0] = '0; model_rdata[1] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    step(1'b0);
    RST = 1'b0;
    repeat (3) step(1'b0);
    new_req(0);
    new_req(1);
    step(1'b0);
    chk("post_rst_winner", 32'(last_win), 32'h0);
    drain();
    for (int n = 0; n < 40 && pend[1]; n++) step(1'b0);
    drain();

    // RD_LAT=3 instance: write then read, read response exactly at T5.
    b_txn("lat3_wr", 4'hF, 7'h10, 32'hCAFEF00D, 2, 32'h0);
    b_txn("lat3_rd", 4'h0, 7'h10, 32'h0, 5, 32'hCAFEF00D);
    b_txn("lat3_rd2", 4'h0, 7'h11, 32'h0, 5, init_val(7'h11));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram128_arbiter.md
Name: ram128_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port RAM128 macro (128 x 32, byte write enables, synchronous read).
- Each requester issues a valid/ready request (read or byte-masked write) and gets a one-cycle response pulse.
- Drives all RAM control/address/data pins from registers and captures read data after a configurable read latency.
- Sits between the two bus-side clients (e.g. management core and user logic) and the RAM macro.

Parameters:
- ADDR_W, 7, RAM word address width.
- DATA_W, 32, RAM data width; byte enables are DATA_W/8.
- RD_LAT, 1, cycles from the RAM sampling edge of EN0 to Do0 valid; legal range 1..4.

Ports:
- CLK  input  1  system clock, all logic posedge.
- RST  input  1  asynchronous, active-high reset.
- m0_valid  input  1  requester 0 request valid; held until accepted.
- m0_we  input  4  byte write enables; 0 = read, nonzero = write.
- m0_addr  input  ADDR_W  word address.
- m0_wdata  input  DATA_W  write data.
- m0_ready  output  1  request accepted this cycle (combinational).
- m0_resp_valid  output  1  one-cycle response pulse.
- m0_rdata  output  DATA_W  read data, valid with m0_resp_valid.
- m1_valid, m1_we, m1_addr, m1_wdata, m1_ready, m1_resp_valid, m1_rdata: same as m0_*, for requester 1.
- ram_EN0  output  1  RAM enable (registered).
- ram_WE0  output  4  RAM byte write enables (registered).
- ram_A0  output  ADDR_W  RAM address (registered).
- ram_Di0  output  DATA_W  RAM write data (registered).
- ram_Do0  input  DATA_W  RAM read data.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, RST=1): state=IDLE; prio=0 (m0 preferred); all outputs 0; latched request and wait counter cleared.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - mK_ready = mK_valid AND (mK wins arbitration); at most one ready per cycle.
  - Arbitration: only one valid wins; both valid wins the prio requester.
  - On accept: latch we/addr/wdata and owner id; set prio to the other requester; go to ACCESS.
- ACCESS, exactly 1 cycle:
  - ram_EN0=1, ram_WE0=latched we, ram_A0/ram_Di0 = latched values.
  - Next state: WAIT if read (we==0), DONE if write.
  - ram_* outputs return to 0 on leaving ACCESS; EN0 is never high outside ACCESS.
- WAIT: counter runs RD_LAT cycles. On the last WAIT cycle, ram_Do0 is captured into the owner's rdata register, then go to DONE.
- DONE, 1 cycle:
  - owner's resp_valid=1, non-owner's resp_valid=0.
  - rdata = captured data for reads, 0 for writes.
  - Next state: IDLE.
- rdata holds its value until the next response to that requester.
- Latency, accept edge = T0:
  - ACCESS in T1.
  - Read resp_valid in T(2+RD_LAT); T3 for RD_LAT=1.
  - Write resp_valid in T2.
- Throughput: one access per 3 (write) or 3+RD_LAT (read) cycles; no ready in any non-IDLE state.
- A request deasserted before acceptance is dropped silently; inputs are ignored outside IDLE.
- No address range check: all 7 bits are passed through; wrap is impossible by width.
- Reset mid-operation: immediate return to IDLE with outputs 0; in-flight access aborted and no response issued; prio returns to 0.

Decomposition:
- Package ram128_arb_pkg holds:
  - state enum (IDLE, ACCESS, WAIT, DONE);
  - ADDR_W/DATA_W/BE_W constants;
  - RD_LAT max constant (4) and counter width.
- Sub-module rr_arb2 is a 2-way round-robin picker. Inputs: req[1:0], prio. Outputs: one-hot gnt[1:0], gnt_id. Purely combinational; the prio register stays in ram128_arbiter.

Test Plan:
- Single read: m0 reads addr 0x05 after a prior m0 write of 0xDEADBEEF, we=4'hF -> m0_ready at T0, ram_EN0=1/A0=0x05 at T1, m0_resp_valid with m0_rdata=0xDEADBEEF at T3 (RD_LAT=1); m1 outputs stay 0.
- Byte write: m1 writes addr 0x7F, wdata=0x11223344, we=4'b0101 -> ram_WE0=4'b0101 at T1, m1_resp_valid at T2 with m1_rdata=0; read back gives only bytes 0 and 2 updated.
- Contention: m0 and m1 both valid continuously after reset -> accepts alternate m0, m1, m0, m1; never two readys in one cycle.
- Latency sweep: RD_LAT=3 -> read resp_valid at T5; Do0 captured on the third WAIT cycle.
- Reset mid-read: RST pulsed during WAIT -> all outputs 0 asynchronously, no resp_valid afterwards, next accept goes to m0 even if m1 also valid.
- Withdrawn request: m1_valid high 1 cycle while busy, then low -> never accepted, no ram_EN0 for it.
